// File: rtl/path_ctrl_if.sv
// Bundle of the handshake and bus signals around path_ctrl: metric source,
// path unit, traceback consumer and status. The slave view belongs to the
// controller itself; the master view belongs to everything around it.
interface path_ctrl_if #(
   parameter int W = 30
);
   logic              in_valid;
   logic              in_ready;
   logic              in_last;
   logic [14*W-1:0]   in_metrics;
   logic [14*W-1:0]   p_metrics;
   logic              p_run;
   logic [3:0]        p_survive;
   logic              p_end;
   logic              out_valid;
   logic              out_ready;
   logic [3:0]        out_survive;
   logic              out_last;
   logic              busy;
   logic              err_timeout;

   modport slave (
      input  in_valid, in_last, in_metrics, p_survive, p_end, out_ready,
      output in_ready, p_metrics, p_run, out_valid, out_survive, out_last,
             busy, err_timeout
   );

   modport master (
      output in_valid, in_last, in_metrics, p_survive, p_end, out_ready,
      input  in_ready, p_metrics, p_run, out_valid, out_survive, out_last,
             busy, err_timeout
   );
endinterface

// File: rtl/path_ctrl.sv
// Step sequencer for the turbo-decoder path unit. Accepts one metric vector
// per trellis step, runs path until it signals path_end (or a timeout),
// stores the survivor, and at frame close streams the survivors back out
// newest first for traceback.
module path_ctrl #(
   parameter int W         = 30,
   parameter int FRAME_LEN = 64,
   parameter int TIMEOUT   = 15
) (
   input  logic        clk,
   input  logic        rst,
   path_ctrl_if.slave  bus
);
   // Pointers carry one extra bit so a full frame count fits.
   localparam int PW = $clog2(FRAME_LEN) + 1;
   localparam int AW = $clog2(FRAME_LEN);
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      CLEAR = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t            state_r, state_s;
   logic [PW-1:0]     wr_ptr_r, wr_ptr_s;
   logic [PW-1:0]     rd_ptr_r, rd_ptr_s;
   logic [CW-1:0]     cyc_cnt_r, cyc_cnt_s;
   logic              last_r, last_s;
   logic              accept_s;
   logic              mem_we_s;
   logic [3:0]        mem_wdata_s;
   logic              set_err_s;

   // Survivor store; never reset because only entries written this frame are read.
   logic [3:0]        mem_r [FRAME_LEN];

   logic [14*W-1:0]   p_metrics_r;
   logic              in_ready_r;
   logic              busy_r;
   logic              p_run_r;
   logic              out_valid_r;
   logic              out_last_r;
   logic [3:0]        out_survive_r;
   logic              err_timeout_r;

   // Next-state, pointer and write-enable decode for the step sequencer
   always_comb begin
      state_s     = state_r;
      wr_ptr_s    = wr_ptr_r;
      rd_ptr_s    = rd_ptr_r;
      cyc_cnt_s   = cyc_cnt_r;
      last_s      = last_r;
      accept_s    = 1'b0;
      mem_we_s    = 1'b0;
      mem_wdata_s = 4'h0;
      set_err_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.in_valid && in_ready_r) begin
               accept_s  = 1'b1;
               last_s    = bus.in_last;
               cyc_cnt_s = '0;
               state_s   = RUN;
            end else begin
               state_s   = IDLE;
            end
         end
         RUN: begin
            cyc_cnt_s = cyc_cnt_r + CW'(1);
            if (bus.p_end) begin
               mem_we_s    = 1'b1;
               mem_wdata_s = bus.p_survive;
               state_s     = CLEAR;
            end else if (cyc_cnt_r == CW'(TIMEOUT)) begin
               // path never finished: record a null survivor and flag it
               mem_we_s    = 1'b1;
               mem_wdata_s = 4'h0;
               set_err_s   = 1'b1;
               state_s     = CLEAR;
            end else begin
               state_s     = RUN;
            end
         end
         CLEAR: begin
            wr_ptr_s = wr_ptr_r + PW'(1);
            // Close on in_last or when the buffer is full; the newest entry is wr_ptr_r.
            if (last_r || ((wr_ptr_r + PW'(1)) == PW'(FRAME_LEN))) begin
               rd_ptr_s = wr_ptr_r;
               state_s  = DRAIN;
            end else begin
               state_s  = IDLE;
            end
         end
         DRAIN: begin
            if (bus.out_ready) begin
               if (rd_ptr_r == '0) begin
                  wr_ptr_s = '0;
                  state_s  = IDLE;
               end else begin
                  rd_ptr_s = rd_ptr_r - PW'(1);
               end
            end else begin
               state_s = DRAIN;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Sequencer state, pointers, step counter, metric holding register and sticky error
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r       <= IDLE;
         wr_ptr_r      <= '0;
         rd_ptr_r      <= '0;
         cyc_cnt_r     <= '0;
         last_r        <= 1'b0;
         p_metrics_r   <= '0;
         err_timeout_r <= 1'b0;
      end else begin
         state_r       <= state_s;
         wr_ptr_r      <= wr_ptr_s;
         rd_ptr_r      <= rd_ptr_s;
         cyc_cnt_r     <= cyc_cnt_s;
         last_r        <= last_s;
         err_timeout_r <= err_timeout_r | set_err_s;
         if (accept_s) begin
            p_metrics_r <= bus.in_metrics;
         end
      end
   end

   // Output registers loaded from the next state so they align with the state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_ready_r    <= 1'b1;
         busy_r        <= 1'b0;
         p_run_r       <= 1'b0;
         out_valid_r   <= 1'b0;
         out_last_r    <= 1'b0;
         out_survive_r <= 4'h0;
      end else begin
         in_ready_r    <= (state_s == IDLE);
         busy_r        <= (state_s != IDLE);
         p_run_r       <= (state_s == RUN);
         out_valid_r   <= (state_s == DRAIN);
         out_last_r    <= (state_s == DRAIN) && (rd_ptr_s == '0);
         out_survive_r <= (state_s == DRAIN) ? mem_r[rd_ptr_s[AW-1:0]] : 4'h0;
      end
   end

   // Survivor write port, one entry per completed step
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_r[wr_ptr_r[AW-1:0]] <= mem_wdata_s;
      end
   end

   assign bus.in_ready    = in_ready_r;
   assign bus.busy        = busy_r;
   assign bus.p_run       = p_run_r;
   assign bus.p_metrics   = p_metrics_r;
   assign bus.out_valid   = out_valid_r;
   assign bus.out_last    = out_last_r;
   assign bus.out_survive = out_survive_r;
   assign bus.err_timeout = err_timeout_r;
endmodule

// File: tb/tb_path_ctrl.sv
// Directed bench for path_ctrl: the bench plays the metric source, the path
// unit (p_end/p_survive) and the traceback consumer, with hand-chosen vectors.
module tb_path_ctrl;
   localparam int W         = 30;
   localparam int FRAME_LEN = 64;
   localparam int TIMEOUT   = 15;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;
   logic [3:0] sv [FRAME_LEN];
   logic [14*W-1:0] m;

   path_ctrl_if #(.W(W)) bus ();

   path_ctrl #(.W(W), .FRAME_LEN(FRAME_LEN), .TIMEOUT(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chkm(input string tag, input logic [14*W-1:0] obs, input logic [14*W-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chki(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One trellis step. Starts at a negedge; k = cycle after accept at which
   // p_end is raised (k=0: never, timeout). Returns at the negedge of T+k+2.
   task automatic do_step(input logic [14*W-1:0] mv, input logic last,
                          input logic [3:0] surv, input int k);
      int n;
      int hi;
      n = 0;
      while (!bus.in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk1("in_ready_wait", bus.in_ready, 1'b1);
      bus.in_valid   = 1'b1;
      bus.in_metrics = mv;
      bus.in_last    = last;
      @(negedge clk);
      bus.in_valid   = 1'b0;
      bus.in_last    = 1'b0;
      bus.in_metrics = '0;
      chkm("p_metrics_run", bus.p_metrics, mv);
      chk1("in_ready_run", bus.in_ready, 1'b0);
      hi = (k == 0) ? TIMEOUT + 1 : k;
      for (int j = 1; j <= hi; j++) begin
         chk1("p_run_high", bus.p_run, 1'b1);
         if (j == k) begin
            bus.p_end     = 1'b1;
            bus.p_survive = surv;
         end
         @(negedge clk);
      end
      bus.p_end     = 1'b0;
      bus.p_survive = 4'h0;
      chk1("p_run_clear", bus.p_run, 1'b0);
      chk1("in_ready_clear", bus.in_ready, 1'b0);
      chkm("p_metrics_hold", bus.p_metrics, mv);
      @(negedge clk);
   endtask

   // Drain n survivors, expecting sv[n-1] down to sv[0]; pat gives the
   // out_ready value per cycle, repeating every four cycles.
   task automatic drain(input int n, input logic [3:0] pat);
      int i;
      int c;
      i = 0;
      c = 0;
      while (i < n && c < 4 * n + 8) begin
         chk1("out_valid", bus.out_valid, 1'b1);
         chk4("out_survive", bus.out_survive, sv[n-1-i]);
         chk1("out_last", bus.out_last, (i == n - 1));
         chk1("in_ready_drain", bus.in_ready, 1'b0);
         bus.out_ready = pat[c % 4];
         @(negedge clk);
         if (bus.out_ready) begin
            i++;
         end
         c++;
      end
      bus.out_ready = 1'b0;
      chki("drain_count", i, n);
      chk1("out_valid_end", bus.out_valid, 1'b0);
      chk4("out_survive_gated", bus.out_survive, 4'h0);
      chk1("in_ready_end", bus.in_ready, 1'b1);
      chk1("busy_end", bus.busy, 1'b0);
   endtask

   initial begin
      n_checks       = 0;
      n_fail         = 0;
      rst            = 1'b1;
      bus.in_valid   = 1'b0;
      bus.in_last    = 1'b0;
      bus.in_metrics = '0;
      bus.p_survive  = 4'h0;
      bus.p_end      = 1'b0;
      bus.out_ready  = 1'b0;
      repeat (3) @(negedge clk);

      // Reset values
      chk1("rst_in_ready", bus.in_ready, 1'b1);
      chk1("rst_busy", bus.busy, 1'b0);
      chk1("rst_p_run", bus.p_run, 1'b0);
      chkm("rst_p_metrics", bus.p_metrics, '0);
      chk1("rst_out_valid", bus.out_valid, 1'b0);
      chk4("rst_out_survive", bus.out_survive, 4'h0);
      chk1("rst_out_last", bus.out_last, 1'b0);
      chk1("rst_err", bus.err_timeout, 1'b0);
      rst = 1'b0;
      @(negedge clk);

      // Single step, p_end at k=3, survivor 5
      m = {30'd40000, 30'd80000, 30'd40000, 30'd0, 30'd80000, 30'd40000, 30'd0,
           30'd40000, 30'd62500, 30'd22500, 30'd2500, 30'd42500, 30'd56900, 30'd4900};
      do_step(m, 1'b1, 4'h5, 3);
      chk1("single_out_valid", bus.out_valid, 1'b1);
      chk4("single_out_survive", bus.out_survive, 4'h5);
      chk1("single_out_last", bus.out_last, 1'b1);
      chk1("single_busy", bus.busy, 1'b1);
      chkm("single_v1", {390'd0, bus.p_metrics[W-1:0]}, 420'd4900);
      chkm("single_v14", {390'd0, bus.p_metrics[14*W-1:13*W]}, 420'd40000);
      sv[0] = 4'h5;
      drain(1, 4'b1111);

      // p_end outside RUN is ignored
      bus.p_end     = 1'b1;
      bus.p_survive = 4'hF;
      repeat (3) @(negedge clk);
      chk1("idle_pend_busy", bus.busy, 1'b0);
      chk1("idle_pend_p_run", bus.p_run, 1'b0);
      bus.p_end     = 1'b0;
      bus.p_survive = 4'h0;

      // Four-step frame, survivors 1..4, first step ends in the first RUN cycle
      sv[0] = 4'h1; sv[1] = 4'h2; sv[2] = 4'h3; sv[3] = 4'h4;
      for (int s = 0; s < 4; s++) begin
         do_step({14{W'(s + 11)}}, (s == 3), sv[s], (s == 0) ? 1 : s + 1);
         chk1("four_in_ready", bus.in_ready, (s != 3));
         chk1("four_out_valid", bus.out_valid, (s == 3));
      end
      drain(4, 4'b1111);

      // Backpressure during drain
      sv[0] = 4'h6; sv[1] = 4'h7; sv[2] = 4'h8; sv[3] = 4'h9;
      for (int s = 0; s < 4; s++) begin
         do_step({14{W'(s + 21)}}, (s == 3), sv[s], 2);
      end
      drain(4, 4'b1001);

      // Frame full without in_last
      for (int s = 0; s < FRAME_LEN; s++) begin
         sv[s] = 4'(s * 5 + 3);
         do_step({14{W'(s + 100)}}, 1'b0, sv[s], (s % 3) + 1);
         chk1("full_in_ready", bus.in_ready, (s != FRAME_LEN - 1));
         chk1("full_out_valid", bus.out_valid, (s == FRAME_LEN - 1));
      end
      drain(FRAME_LEN, 4'b1111);
      sv[0] = 4'h7;
      do_step({14{W'(7)}}, 1'b1, 4'h7, 1);
      chk4("after_full_survive", bus.out_survive, 4'h7);
      drain(1, 4'b1111);

      // Timeout step
      chk1("err_before_timeout", bus.err_timeout, 1'b0);
      do_step({14{W'(99)}}, 1'b1, 4'hE, 0);
      chk1("timeout_err", bus.err_timeout, 1'b1);
      sv[0] = 4'h0;
      drain(1, 4'b1111);
      sv[0] = 4'hC;
      do_step({14{W'(55)}}, 1'b1, 4'hC, 2);
      chk1("err_sticky", bus.err_timeout, 1'b1);
      drain(1, 4'b1111);

      // Reset mid-drain after two of four outputs
      sv[0] = 4'h1; sv[1] = 4'h2; sv[2] = 4'h3; sv[3] = 4'h4;
      for (int s = 0; s < 4; s++) begin
         do_step({14{W'(s + 31)}}, (s == 3), sv[s], 1);
      end
      for (int j = 0; j < 2; j++) begin
         chk4("partial_survive", bus.out_survive, sv[3-j]);
         bus.out_ready = 1'b1;
         @(negedge clk);
      end
      bus.out_ready = 1'b0;
      chk4("partial_third", bus.out_survive, 4'h2);
      rst = 1'b1;
      #1;
      chk1("mid_rst_in_ready", bus.in_ready, 1'b1);
      chk1("mid_rst_busy", bus.busy, 1'b0);
      chk1("mid_rst_p_run", bus.p_run, 1'b0);
      chkm("mid_rst_p_metrics", bus.p_metrics, '0);
      chk1("mid_rst_out_valid", bus.out_valid, 1'b0);
      chk4("mid_rst_out_survive", bus.out_survive, 4'h0);
      chk1("mid_rst_out_last", bus.out_last, 1'b0);
      chk1("mid_rst_err", bus.err_timeout, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Next frame drains only its own two entries
      sv[0] = 4'h9; sv[1] = 4'hA;
      do_step({14{W'(41)}}, 1'b0, sv[0], 2);
      do_step({14{W'(42)}}, 1'b1, sv[1], 3);
      drain(2, 4'b1111);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/path_ctrl.md
# path_ctrl

Step sequencer for the turbo-decoder `path` unit. It accepts one 14-metric vector per trellis step over a valid/ready handshake and presents it to `path`. It runs and clears `path` around each step, captures `c_survive` on `path_end` into a frame-deep survivor buffer, and streams the buffer out in reverse (traceback) order when the frame closes. It sits between the metric-generation stage and the traceback/decision stage.

## Interface
- `W`, 30, width of one path metric (matches `v_1`..`v_14`)
- `FRAME_LEN`, 64, survivor buffer depth (steps per frame, max)
- `TIMEOUT`, 15, max cycles to wait for `p_end` per step
- `clk` in 1: the block's one clock; all state changes on its rising edge
- `rst` in 1: asynchronous, active-high reset
- `in_valid` in 1: metric vector valid
- `in_ready` out 1: controller can accept a vector
- `in_last` in 1: this vector is the last step of the frame
- `in_metrics` in 14*W: packed metrics, bits [W-1:0] = v_1 … top slice = v_14
- `p_metrics` out 14*W: registered metrics to `path` v_1..v_14, same packing
- `p_run` out 1: drives `path.rst`; 0 holds `path` cleared, 1 lets it compute
- `p_survive` in 4: `path.c_survive`
- `p_end` in 1: `path.path_end`
- `out_valid` out 1: survivor output valid
- `out_ready` in 1: downstream accepts survivor
- `out_survive` out 4: survivor, newest step first
- `out_last` out 1: marks step 0 (oldest) of the frame
- `busy` out 1: state is not IDLE
- `err_timeout` out 1: sticky; a step hit TIMEOUT

## Operation
- States: IDLE, RUN, CLEAR, DRAIN.
- IDLE:
  - `in_ready`=1.
  - On `in_valid & in_ready`, register `in_metrics` into `p_metrics`, latch `in_last` into `last_q`, clear `cyc_cnt`, and go to RUN.
- RUN:
  - `p_run`=1; `cyc_cnt` increments each cycle, starting at 0 in the first RUN cycle.
  - If `p_end`=1, write `p_survive` to `mem[wr_ptr]` and go to CLEAR.
  - Else if `cyc_cnt`==TIMEOUT, write 4'h0 to `mem[wr_ptr]`, set `err_timeout`, and go to CLEAR.
- CLEAR:
  - Lasts exactly one cycle; `p_run`=0.
  - `wr_ptr` increments, written as "`wr_ptr` <= `wr_ptr`+1".
  - If `last_q`, or the new count equals FRAME_LEN, go to DRAIN with `rd_ptr` = count-1. Otherwise go to IDLE.
- DRAIN:
  - `out_valid`=1, `out_survive`=`mem[rd_ptr]`, `out_last`=(`rd_ptr`==0).
  - On `out_valid & out_ready`: if `rd_ptr`==0, go to IDLE with `wr_ptr`=0; otherwise decrement `rd_ptr`.
  - Output holds stable while `out_ready`=0.
- `p_end` is ignored outside RUN. `p_metrics` holds its value until the next accept.
- `in_ready` is 0 in RUN, CLEAR and DRAIN; no new frame is accepted until the drain completes.
- Forced close at FRAME_LEN:
  - A frame reaching FRAME_LEN steps without `in_last` is closed and drained as if `in_last` had been seen.
  - The next vector starts a new frame.
- Pointers are `$clog2(FRAME_LEN)+1` bits wide. The survivor memory is a register array; its contents are not reset, since only written entries are read.
- `err_timeout` clears only on `rst`.

## Timing
- Reset values:
  - state IDLE, so `in_ready`=1 and `busy`=0.
  - `p_run`=0, `p_metrics`=0.
  - `out_valid`=0, `out_survive`=0 (gated to 0 when `out_valid`=0), `out_last`=0.
  - `err_timeout`=0, `wr_ptr`=`rd_ptr`=0.
- Per-step latency, with accept at cycle T and `p_end` first seen at cycle T+k (k≥1):
  - `p_metrics` valid and `p_run`=1 from T+1.
  - Survivor written at the end of T+k.
  - `p_run`=0 at T+k+1.
  - `in_ready`=1 again at T+k+2, or `out_valid`=1 at T+k+2 on frame close.
- Timeout step: `p_run` is high for TIMEOUT+1 cycles, then CLEAR.
- `p_end` asserted in the first RUN cycle is honoured.
- DRAIN throughput is one survivor per cycle while `out_ready`=1.
- `rst` mid-operation, any state:
  - Immediate return to reset values; `p_run` drops asynchronously.
  - Partial frame discarded.

## Test plan
- Single step: accept metrics v_1..v_14 = 4900, 56900, 42500, 2500, 22500, 62500, 40000, 0, 40000, 80000, 0, 40000, 80000, 40000 with `in_last`=1; model `path` returns 4'h5 with `p_end` at k=3 → `p_run` high T+1..T+3, then `out_valid` at T+5 with `out_survive`=5 and `out_last`=1.
- Four-step frame, survivors 1,2,3,4 → output order 4,3,2,1; `out_last` only with 1; `in_ready` low until the final handshake.
- Backpressure: `out_ready` toggled 1,0,0,1 during drain → `out_survive` stable while stalled; no entry lost or repeated.
- Timeout: `p_end` never asserted → `p_run` high 16 cycles, survivor 0 stored, `err_timeout`=1 and stays set through the next frame.
- Frame full: FRAME_LEN vectors without `in_last` → drain of FRAME_LEN entries starts automatically; the next accepted vector writes `mem[0]`.
- Reset mid-DRAIN after 2 of 4 outputs → all outputs at reset values; the next frame drains only its own entries.
